// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between execute and the data memory port.
// Decodes LOAD/STORE, builds byte enables and lane-shifted store data, runs a
// req/ack handshake with timeout and returns extended load data.
// Optional build macro: MISALIGN_TRAP_EN (trap misaligned accesses instead of
// forcing natural alignment).
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         inst,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   store_data,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   load_data,
    output logic                resp_misaligned,
    output logic                resp_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]    mem_be_q, mem_be_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [1:0]         size_q, size_d;
    logic               zext_q, zext_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [DATA_W-1:0]  load_data_q, load_data_d;
    logic               err_q, err_d;
    logic               mis_q, mis_d;

    logic [1:0]         size;
    logic               zext, is_load, is_store, is_mem, illegal, misaligned;
    logic [LANE_W-1:0]  lane;
    logic [BE_W-1:0]    be_base;
    logic [DATA_W-1:0]  shifted, extracted;
    logic               sign_bit;

    // Instruction bits that play no part in a memory access.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst[31:15], inst[11:7]};

    // Decode the presented instruction: class, size, legality, lane and enables.
    always_comb begin
        int nbytes;
        size     = inst[13:12];
        zext     = inst[14];
        is_load  = (inst[6:0] == OP_LOAD);
        is_store = (inst[6:0] == OP_STORE);
        is_mem   = is_load | is_store;
        // Stores have no unsigned form; 32-bit memories have no D or LWU.
        illegal  = is_mem && ((is_store && zext) ||
                   ((DATA_W == 32) && ((size == 2'd3) || (is_load && zext && size == 2'd2))));
`ifdef MISALIGN_TRAP_EN
        case (size)
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = (addr[1:0] != 2'b00);
            2'd3:    misaligned = (addr[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
`else
        misaligned = 1'b0;
`endif
        // Clearing lane bits below the size gives natural alignment; a no-op
        // for aligned addresses, which are the only ones reaching memory in trap mode.
        lane = addr[LANE_W-1:0];
        for (int i = 0; i < LANE_W; i++) begin
            if (i < int'(size)) lane[i] = 1'b0;
        end
        nbytes = 1 << size;
        for (int i = 0; i < BE_W; i++) begin
            be_base[i] = (i < nbytes);
        end
    end

    // Align returned data to bit 0, truncate to the access size and extend.
    always_comb begin
        int nbits;
        shifted = mem_rdata >> {lane_q, 3'b000};
        nbits   = 8 << size_q;
        case (size_q)
            2'd0:    sign_bit = shifted[7];
            2'd1:    sign_bit = shifted[15];
            2'd2:    sign_bit = shifted[31];
            default: sign_bit = shifted[DATA_W-1];
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            extracted[i] = (i < nbits) ? shifted[i] : (sign_bit & ~zext_q);
        end
    end

    // Next-state logic: accept in IDLE, handshake/timeout in REQ, one-cycle RESP.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        size_d      = size_q;
        zext_d      = zext_q;
        lane_d      = lane_q;
        load_data_d = load_data_q;
        err_d       = err_q;
        mis_d       = mis_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_we_d    = is_store;
                    mem_addr_d  = {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                    mem_be_d    = be_base << lane;
                    mem_wdata_d = store_data << {lane, 3'b000};
                    size_d      = size;
                    zext_d      = zext;
                    lane_d      = lane;
                    wait_d      = '0;
                    load_data_d = '0;
                    err_d       = illegal;
                    mis_d       = is_mem & ~illegal & misaligned;
                    state_d     = (is_mem && !illegal && !misaligned) ? REQ : RESP;
                end
            end
            REQ: begin
                // An ack in the final allowed cycle still completes normally.
                if (mem_ack) begin
                    state_d = RESP;
                    if (!mem_we_q) load_data_d = extracted;
                end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            size_q      <= '0;
            zext_q      <= 1'b0;
            lane_q      <= '0;
            load_data_q <= '0;
            err_q       <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            size_q      <= size_d;
            zext_q      <= zext_d;
            lane_q      <= lane_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
            mis_q       <= mis_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign mem_req         = (state_q == REQ);
    assign resp_valid      = (state_q == RESP);
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_be          = mem_be_q;
    assign mem_wdata       = mem_wdata_q;
    assign load_data       = load_data_q;
    assign resp_err        = err_q;
    assign resp_misaligned = mis_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit and a 64-bit instance, both TIMEOUT=4.
module tb_mem_access_unit;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Shared stimulus
    logic [31:0] inst, addr;
    logic [63:0] sd, rd;
    logic        rv_a, rv_b, ack_a, ack_b;

    // 32-bit instance outputs
    logic        rdy_a, resp_a, mis_a, err_a, mreq_a, mwe_a;
    logic [31:0] ld_a, maddr_a, mwd_a;
    logic [3:0]  be_a;
    // 64-bit instance outputs
    logic        rdy_b, resp_b, mis_b, err_b, mreq_b, mwe_b;
    logic [63:0] ld_b, mwd_b;
    logic [31:0] maddr_b;
    logic [7:0]  be_b;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_a (
        .clock(clock), .reset(reset), .req_valid(rv_a), .req_ready(rdy_a),
        .inst(inst), .addr(addr), .store_data(sd[31:0]), .resp_valid(resp_a),
        .load_data(ld_a), .resp_misaligned(mis_a), .resp_err(err_a),
        .mem_req(mreq_a), .mem_we(mwe_a), .mem_addr(maddr_a), .mem_be(be_a),
        .mem_wdata(mwd_a), .mem_ack(ack_a), .mem_rdata(rd[31:0]));

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u_b (
        .clock(clock), .reset(reset), .req_valid(rv_b), .req_ready(rdy_b),
        .inst(inst), .addr(addr), .store_data(sd), .resp_valid(resp_b),
        .load_data(ld_b), .resp_misaligned(mis_b), .resp_err(err_b),
        .mem_req(mreq_b), .mem_we(mwe_b), .mem_addr(maddr_b), .mem_be(be_b),
        .mem_wdata(mwd_b), .mem_ack(ack_b), .mem_rdata(rd));

    // Observed outputs of whichever instance is under test
    logic        sel64;
    logic        o_rdy, o_resp, o_mis, o_err, o_mreq, o_mwe;
    logic [63:0] o_ld, o_mwd;
    logic [31:0] o_maddr;
    logic [7:0]  o_be;
    assign o_rdy   = sel64 ? rdy_b  : rdy_a;
    assign o_resp  = sel64 ? resp_b : resp_a;
    assign o_mis   = sel64 ? mis_b  : mis_a;
    assign o_err   = sel64 ? err_b  : err_a;
    assign o_mreq  = sel64 ? mreq_b : mreq_a;
    assign o_mwe   = sel64 ? mwe_b  : mwe_a;
    assign o_ld    = sel64 ? ld_b   : {32'h0, ld_a};
    assign o_mwd   = sel64 ? mwd_b  : {32'h0, mwd_a};
    assign o_maddr = sel64 ? maddr_b : maddr_a;
    assign o_be    = sel64 ? be_b   : {4'h0, be_a};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          sel64;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [63:0] sd;
        logic [63:0] rd;
        bit          has_mem;
        int          ack_dly;
        bit          we;
        logic [31:0] maddr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [63:0] load;
        bit          err;
        bit          mis;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] op);
        return {17'h0, f3, 5'd3, op};
    endfunction

    function automatic vec_t mk(input bit s64, input logic [31:0] in, input logic [31:0] a,
                                input logic [63:0] s, input logic [63:0] r, input bit hm,
                                input int dly, input bit w, input logic [31:0] ma,
                                input logic [7:0] b, input logic [63:0] wd,
                                input logic [63:0] l, input bit e, input bit m);
        vec_t v;
        v.sel64 = s64; v.inst = in; v.addr = a; v.sd = s; v.rd = r; v.has_mem = hm;
        v.ack_dly = dly; v.we = w; v.maddr = ma; v.be = b; v.wdata = wd; v.load = l;
        v.err = e; v.mis = m;
        return v;
    endfunction

    // One complete transaction: accept, optional memory phase, response, back to idle.
    task automatic run_vec(input int idx, input vec_t v);
        logic [63:0] m;
        sel64 = v.sel64;
        @(negedge clock);
        chk("ready_before", {63'h0, o_rdy}, 64'd1);
        inst = v.inst; addr = v.addr; sd = v.sd; rd = v.rd;
        if (v.sel64) rv_b = 1'b1; else rv_a = 1'b1;
        @(posedge clock);
        #1 rv_a = 1'b0; rv_b = 1'b0;
        @(negedge clock);
        if (v.has_mem) begin
            chk("mem_req", {63'h0, o_mreq}, 64'd1);
            chk("mem_we", {63'h0, o_mwe}, {63'h0, v.we});
            chk("mem_addr", {32'h0, o_maddr}, {32'h0, v.maddr});
            chk("mem_be", {56'h0, o_be}, {56'h0, v.be});
            if (v.we) begin
                m = '0;
                for (int b = 0; b < 8; b++) if (v.be[b]) m[8*b +: 8] = 8'hFF;
                chk("mem_wdata", o_mwd & m, v.wdata & m);
            end
            for (int d = 0; d < v.ack_dly; d++) begin
                @(negedge clock);
                chk("req_hold", {63'h0, o_mreq}, 64'd1);
                chk("no_early_resp", {63'h0, o_resp}, 64'd0);
            end
            if (v.sel64) ack_b = 1'b1; else ack_a = 1'b1;
            @(posedge clock);
            #1 ack_a = 1'b0; ack_b = 1'b0;
            @(negedge clock);
        end else begin
            chk("no_mem_req", {63'h0, o_mreq}, 64'd0);
        end
        chk("resp_valid", {63'h0, o_resp}, 64'd1);
        chk("load_data", o_ld, v.load);
        chk("resp_err", {63'h0, o_err}, {63'h0, v.err});
        chk("resp_mis", {63'h0, o_mis}, {63'h0, v.mis});
        chk("req_low_resp", {63'h0, o_mreq}, 64'd0);
        chk("ready_in_resp", {63'h0, o_rdy}, 64'd0);
        @(negedge clock);
        chk("resp_pulse", {63'h0, o_resp}, 64'd0);
        chk("ready_after", {63'h0, o_rdy}, 64'd1);
        $display("vec %0d w64=%0d inst=%h addr=%h load=%h err=%0d mis=%0d",
                 idx, v.sel64, v.inst, v.addr, o_ld, o_err, o_mis);
    endtask

    initial begin
        int cnt, seen, extra;
        // 32-bit vectors
        vt.push_back(mk(0, mk_inst(3'd0, ST), 32'h1003, 64'hA5, 64'h0, 1, 0, 1, 32'h1000, 8'h08, 64'hA500_0000, 64'h0, 0, 0));
        vt.push_back(mk(0, mk_inst(3'd1, LD), 32'h2002, 64'h0, 64'h8001_0000, 1, 0, 0, 32'h2000, 8'h0C, 64'h0, 64'hFFFF_8001, 0, 0));
        vt.push_back(mk(0, mk_inst(3'd5, LD), 32'h2002, 64'h0, 64'h8001_0000, 1, 0, 0, 32'h2000, 8'h0C, 64'h0, 64'h0000_8001, 0, 0));
        vt.push_back(mk(0, mk_inst(3'd0, LD), 32'h3001, 64'h0, 64'h1234_8056, 1, 0, 0, 32'h3000, 8'h02, 64'h0, 64'hFFFF_FF80, 0, 0));
        vt.push_back(mk(0, mk_inst(3'd4, LD), 32'h3001, 64'h0, 64'h1234_8056, 1, 0, 0, 32'h3000, 8'h02, 64'h0, 64'h0000_0080, 0, 0));
        vt.push_back(mk(0, mk_inst(3'd2, LD), 32'h4000, 64'h0, 64'hDEAD_BEEF, 1, 2, 0, 32'h4000, 8'h0F, 64'h0, 64'hDEAD_BEEF, 0, 0));
        vt.push_back(mk(0, mk_inst(3'd1, ST), 32'h5002, 64'h1234_BEEF, 64'h0, 1, 0, 1, 32'h5000, 8'h0C, 64'hBEEF_0000, 64'h0, 0, 0));
        // ack arriving in the last cycle before timeout must win
        vt.push_back(mk(0, mk_inst(3'd2, ST), 32'h6004, 64'hCAFE_F00D, 64'h0, 1, 3, 1, 32'h6004, 8'h0F, 64'hCAFE_F00D, 64'h0, 0, 0));
        vt.push_back(mk(0, mk_inst(3'd3, LD), 32'h7000, 64'h0, 64'h0, 0, 0, 0, 32'h0, 8'h0, 64'h0, 64'h0, 1, 0));
        vt.push_back(mk(0, mk_inst(3'd6, LD), 32'h7000, 64'h0, 64'h0, 0, 0, 0, 32'h0, 8'h0, 64'h0, 64'h0, 1, 0));
        vt.push_back(mk(0, mk_inst(3'd4, ST), 32'h7000, 64'h5, 64'h0, 0, 0, 0, 32'h0, 8'h0, 64'h0, 64'h0, 1, 0));
        vt.push_back(mk(0, mk_inst(3'd0, 7'h13), 32'h7000, 64'h5, 64'h0, 0, 0, 0, 32'h0, 8'h0, 64'h0, 64'h0, 0, 0));
`ifdef MISALIGN_TRAP_EN
        vt.push_back(mk(0, mk_inst(3'd2, LD), 32'h1002, 64'h0, 64'h1122_3344, 0, 0, 0, 32'h0, 8'h0, 64'h0, 64'h0, 0, 1));
        vt.push_back(mk(0, mk_inst(3'd1, ST), 32'h5003, 64'h7777, 64'h0, 0, 0, 0, 32'h0, 8'h0, 64'h0, 64'h0, 0, 1));
`else
        vt.push_back(mk(0, mk_inst(3'd2, LD), 32'h1002, 64'h0, 64'h1122_3344, 1, 0, 0, 32'h1000, 8'h0F, 64'h0, 64'h1122_3344, 0, 0));
        vt.push_back(mk(0, mk_inst(3'd1, ST), 32'h5003, 64'h7777, 64'h0, 1, 0, 1, 32'h5000, 8'h0C, 64'h7777_0000, 64'h0, 0, 0));
`endif
        // 64-bit vectors
        vt.push_back(mk(1, mk_inst(3'd3, LD), 32'h10, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0, 0, 32'h10, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0));
        vt.push_back(mk(1, mk_inst(3'd6, LD), 32'h14, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0, 0, 32'h10, 8'hF0, 64'h0, 64'h0000_0000_0123_4567, 0, 0));
        vt.push_back(mk(1, mk_inst(3'd2, LD), 32'h14, 64'h0, 64'h8000_0000_0000_0000, 1, 1, 0, 32'h10, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0000, 0, 0));
        vt.push_back(mk(1, mk_inst(3'd3, ST), 32'h28, 64'h1122_3344_5566_7788, 64'h0, 1, 0, 1, 32'h28, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0, 0));
        vt.push_back(mk(1, mk_inst(3'd0, ST), 32'h2F, 64'h5A, 64'h0, 1, 0, 1, 32'h28, 8'h80, 64'h5A00_0000_0000_0000, 64'h0, 0, 0));
        vt.push_back(mk(1, mk_inst(3'd6, ST), 32'h28, 64'h1, 64'h0, 0, 0, 0, 32'h0, 8'h0, 64'h0, 64'h0, 1, 0));

        sel64 = 1'b0;
        inst = '0; addr = '0; sd = '0; rd = '0;
        rv_a = 1'b0; rv_b = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_ready_a", {63'h0, rdy_a}, 64'd1);
        chk("rst_ready_b", {63'h0, rdy_b}, 64'd1);
        chk("rst_resp_a", {63'h0, resp_a}, 64'd0);
        chk("rst_mreq_a", {63'h0, mreq_a}, 64'd0);
        chk("rst_mreq_b", {63'h0, mreq_b}, 64'd0);
        chk("rst_load_a", {32'h0, ld_a}, 64'd0);
        chk("rst_err_b", {63'h0, err_b}, 64'd0);

        for (int i = 0; i < vt.size(); i++) run_vec(i, vt[i]);

        // Timeout: no ack ever, mem_req for exactly 4 cycles, then error response.
        sel64 = 1'b0;
        @(negedge clock);
        inst = mk_inst(3'd2, LD); addr = 32'h100; rv_a = 1'b1;
        @(posedge clock);
        #1 rv_a = 1'b0;
        cnt = 0; seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clock);
            if (o_resp) seen = 1;
            else if (o_mreq) cnt++;
        end
        chk("to_resp_seen", 64'(seen), 64'd1);
        chk("to_req_cycles", 64'(cnt), 64'd4);
        chk("to_err", {63'h0, o_err}, 64'd1);
        chk("to_load", o_ld, 64'd0);
        chk("to_req_dropped", {63'h0, o_mreq}, 64'd0);
        @(negedge clock);
        chk("to_ready_after", {63'h0, o_rdy}, 64'd1);
        $display("timeout seq: req_cycles=%0d err=%0d", cnt, err_a);

        // Reset while in REQ: abandoned transaction never responds.
        @(negedge clock);
        inst = mk_inst(3'd2, LD); addr = 32'h200; rv_a = 1'b1;
        @(posedge clock);
        #1 rv_a = 1'b0;
        @(negedge clock);
        chk("rr_req1", {63'h0, o_mreq}, 64'd1);
        @(negedge clock);
        chk("rr_req2", {63'h0, o_mreq}, 64'd1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rr_req_off", {63'h0, o_mreq}, 64'd0);
        chk("rr_ready", {63'h0, o_rdy}, 64'd1);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            if (o_resp) extra++;
            @(negedge clock);
        end
        chk("rr_no_resp", 64'(extra), 64'd0);
        $display("reset-in-req seq: stray responses=%0d", extra);
        run_vec(100, mk(0, mk_inst(3'd2, LD), 32'h300, 64'h0, 64'h0BAD_F00D, 1, 1, 0, 32'h300, 8'h0F, 64'h0, 64'h0BAD_F00D, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
